// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports and NWR write ports
// with same-cycle bypass, a per-register busy scoreboard, and a post-reset
// zeroing sweep so the array itself carries no reset.
module regfile_mp #(
   parameter  int unsigned XLEN  = 32,
   parameter  int unsigned NREGS = 32,
   parameter  int unsigned NRD   = 2,
   parameter  int unsigned NWR   = 2,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NRD*AW-1:0]   rs,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rbusy,
   input  logic [NWR*AW-1:0]   wreg,
   input  logic [NWR*XLEN-1:0] wdata,
   input  logic [NWR-1:0]      wen,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_reg,
   output logic                ready
);

   typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [AW-1:0]    cnt, cnt_nxt;
   logic [NREGS-1:0] busy, busy_nxt;
   logic [XLEN-1:0]  regs [NREGS];

   // State, sweep counter and busy scoreboard registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_INIT;
         cnt   <= AW'(1);
         busy  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         busy  <= busy_nxt;
      end
   end

   // Next-state: sweep in INIT; scoreboard update in RUN (alloc set beats write clear)
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      busy_nxt  = busy;
      case (state)
         S_INIT: begin
            if (cnt == AW'(NREGS - 1)) begin
               state_nxt = S_RUN;
            end else begin
               cnt_nxt = cnt + AW'(1);
            end
         end
         S_RUN: begin
            for (int j = 0; j < NWR; j++) begin
               if (wen[j]) busy_nxt[wreg[j*AW +: AW]] = 1'b0;
            end
            if (alloc_en) busy_nxt[alloc_reg] = 1'b1;
         end
         default: state_nxt = S_INIT;
      endcase
      busy_nxt[0] = 1'b0;
   end

   // Array writes: sweep zeroes in INIT, port writes in RUN (highest port wins)
   always_ff @(posedge clk) begin
      if (state == S_INIT) begin
         regs[cnt] <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (wen[j] && (wreg[j*AW +: AW] != '0)) begin
               regs[wreg[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
            end
         end
      end
   end

   // Read ports: x0 forced to zero, bypass from highest matching write port
   always_comb begin : rd_mux
      logic [AW-1:0]   idx;
      logic [XLEN-1:0] val;
      logic            hit;
      rdata = '0;
      rbusy = '0;
      idx   = '0;
      val   = '0;
      hit   = 1'b0;
      for (int i = 0; i < NRD; i++) begin
         idx = rs[i*AW +: AW];
         val = regs[idx];
         hit = 1'b0;
         for (int j = 0; j < NWR; j++) begin
            if ((state == S_RUN) && wen[j] && (wreg[j*AW +: AW] == idx)) begin
               val = wdata[j*XLEN +: XLEN];
               hit = 1'b1;
            end
         end
         if (idx == '0) val = '0;
         rdata[i*XLEN +: XLEN] = val;
         rbusy[i]              = busy[idx] & ~hit;
      end
   end

   assign ready = (state == S_RUN);

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expected read-port results
// computed from a behavioural model; a negedge monitor pops and compares.
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;

   logic                clk;
   logic                reset_n;
   logic [NRD*AW-1:0]   rs;
   logic [NRD*XLEN-1:0] rdata;
   logic [NRD-1:0]      rbusy;
   logic [NWR*AW-1:0]   wreg;
   logic [NWR*XLEN-1:0] wdata;
   logic [NWR-1:0]      wen;
   logic                alloc_en;
   logic [AW-1:0]       alloc_reg;
   logic                ready;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
      .clk(clk), .reset_n(reset_n), .rs(rs), .rdata(rdata), .rbusy(rbusy),
      .wreg(wreg), .wdata(wdata), .wen(wen), .alloc_en(alloc_en),
      .alloc_reg(alloc_reg), .ready(ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [NRD*XLEN-1:0] d;
      logic [NRD-1:0]      dchk;
      logic [NRD-1:0]      rb;
      logic                rdy;
      int                  tag;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cur_tag = 0;

   // Behavioural model
   logic [XLEN-1:0] m_mem   [NREGS];
   bit              m_known [NREGS];
   bit              m_busy  [NREGS];
   bit              m_ready;
   int              m_edges;

   task automatic model_reset();
      m_ready = 0;
      m_edges = 0;
      for (int k = 0; k < NREGS; k++) begin
         m_busy[k]  = 0;
         m_known[k] = 0;
      end
   endtask

   task automatic model_edge();
      if (!m_ready) begin
         m_edges++;
         m_mem[m_edges]   = '0;
         m_known[m_edges] = 1;
         if (m_edges == NREGS - 1) m_ready = 1;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            int r;
            r = int'(wreg[j*AW +: AW]);
            if (wen[j]) begin
               m_busy[r] = 0;
               if (r != 0) m_mem[r] = wdata[j*XLEN +: XLEN];
            end
         end
         if (alloc_en && alloc_reg != '0) m_busy[int'(alloc_reg)] = 1;
      end
   endtask

   // Push the expected outputs for the current input pattern, then clock it
   task automatic step();
      exp_t            e;
      int              idx;
      bit              hit;
      logic [XLEN-1:0] v;
      if (!reset_n) model_reset();
      e = '0;
      e.rdy = m_ready;
      e.tag = cur_tag;
      for (int i = 0; i < NRD; i++) begin
         idx = int'(rs[i*AW +: AW]);
         hit = 0;
         v   = '0;
         for (int j = 0; j < NWR; j++) begin
            if (m_ready && wen[j] && int'(wreg[j*AW +: AW]) == idx) begin
               hit = 1;
               v   = wdata[j*XLEN +: XLEN];
            end
         end
         if (idx == 0) begin
            e.dchk[i] = 1'b1;
         end else if (hit) begin
            e.d[i*XLEN +: XLEN] = v;
            e.dchk[i] = 1'b1;
         end else if (m_known[idx]) begin
            e.d[i*XLEN +: XLEN] = m_mem[idx];
            e.dchk[i] = 1'b1;
         end
         e.rb[i] = (idx != 0) && m_busy[idx] && !hit;
      end
      q.push_back(e);
      @(posedge clk);
      if (reset_n) model_edge();
      #1;
   endtask

   // Monitor: outputs are valid every cycle, compare at the falling edge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         bit   bad;
         e   = q.pop_front();
         bad = 0;
         n_vec++;
         if (ready !== e.rdy) begin
            $display("FAIL t%0d ready got %b exp %b", e.tag, ready, e.rdy);
            bad = 1;
         end
         if (rbusy !== e.rb) begin
            $display("FAIL t%0d rbusy got %b exp %b", e.tag, rbusy, e.rb);
            bad = 1;
         end
         for (int i = 0; i < NRD; i++) begin
            if (e.dchk[i] && rdata[i*XLEN +: XLEN] !== e.d[i*XLEN +: XLEN]) begin
               $display("FAIL t%0d rdata[%0d] got %h exp %h", e.tag, i,
                        rdata[i*XLEN +: XLEN], e.d[i*XLEN +: XLEN]);
               bad = 1;
            end
         end
         if (bad) n_err++;
      end
   end

   task automatic idle();
      wen      = '0;
      alloc_en = 1'b0;
   endtask

   task automatic set_rs(input int i, input int r);
      rs[i*AW +: AW] = AW'(r);
   endtask

   task automatic set_wr(input int j, input bit en, input int r, input logic [XLEN-1:0] d);
      wen[j]               = en;
      wreg[j*AW +: AW]     = AW'(r);
      wdata[j*XLEN +: XLEN] = d;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle();
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      rs        = '0;
      wreg      = '0;
      wdata     = '0;
      wen       = '0;
      alloc_en  = 1'b0;
      alloc_reg = '0;
      model_reset();
      @(posedge clk);
      #1;

      // Reset, then a mid-sweep restart after 10 edges, then a full sweep
      cur_tag = 1;
      do_reset();
      repeat (10) step();
      do_reset();
      repeat (NREGS + 2) step();

      // Every register reads zero after the sweep
      cur_tag = 2;
      for (int k = 0; k < NREGS; k += 2) begin
         set_rs(0, k);
         set_rs(1, k + 1);
         step();
      end

      // Collision on x5: port 1 wins, bypass then array
      cur_tag = 3;
      set_wr(0, 1, 5, 32'hAAAA0000);
      set_wr(1, 1, 5, 32'hBBBB0000);
      set_rs(0, 5);
      set_rs(1, 4);
      step();
      idle();
      step();

      // Writes to x0 are dropped
      cur_tag = 4;
      set_wr(0, 1, 0, 32'hDEADBEEF);
      set_wr(1, 1, 0, 32'hDEADBEEF);
      set_rs(0, 0);
      set_rs(1, 0);
      step();
      idle();
      step();

      // Alloc x7, then a write clears busy with bypass
      cur_tag = 5;
      set_rs(0, 7);
      set_rs(1, 5);
      alloc_en  = 1'b1;
      alloc_reg = AW'(7);
      step();
      idle();
      step();
      set_wr(0, 1, 7, 32'h1234);
      step();
      idle();
      step();

      // Same-edge alloc and write to x9: busy stays set, data lands
      cur_tag = 6;
      set_rs(0, 9);
      set_rs(1, 7);
      alloc_en  = 1'b1;
      alloc_reg = AW'(9);
      set_wr(1, 1, 9, 32'h55);
      step();
      idle();
      step();

      // Reset from RUN; writes and allocs during INIT are ignored
      cur_tag = 7;
      set_rs(0, 3);
      set_rs(1, 9);
      do_reset();
      repeat (5) step();
      set_wr(0, 1, 3, 32'hFF);
      alloc_en  = 1'b1;
      alloc_reg = AW'(3);
      step();
      idle();
      repeat (NREGS) step();

      // Randomized traffic on a narrow register window to force collisions
      cur_tag = 8;
      for (int n = 0; n < 1500; n++) begin
         for (int j = 0; j < NWR; j++)
            set_wr(j, bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
         for (int i = 0; i < NRD; i++) begin
            if ($urandom_range(0, 3) == 0)
               set_rs(i, int'(wreg[($urandom_range(0, NWR - 1))*AW +: AW]));
            else
               set_rs(i, int'($urandom_range(0, 7)));
         end
         alloc_en  = ($urandom_range(0, 2) == 0);
         alloc_reg = AW'($urandom_range(0, 7));
         step();
      end
      idle();
      step();

      repeat (2) @(negedge clk);
      if (q.size() != 0) begin
         $display("FAIL drain %0d entries left exp 0", q.size());
         n_err++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file, successor to the 2-read/1-write file in the decode/writeback path. It provides NRD combinational read ports and NWR write ports, each with write-to-read bypass. A per-register busy scoreboard lets issue logic detect pending producers. Contents are zeroed by a post-reset sweep FSM instead of an asynchronous array reset, so the array can map to distributed RAM.

## Interface
- XLEN, 32, data width
- NREGS, 32, architectural register count (power of two, >= 4); register 0 is hardwired zero
- NRD, 2, read port count
- NWR, 2, write port count
- AW, $clog2(NREGS), derived index width (localparam)

- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rs  in  NRD*AW  read indices; port i at bits [i*AW +: AW]
- rdata  out  NRD*XLEN  read data; port i at [i*XLEN +: XLEN]
- rbusy  out  NRD  port i source has a pending producer not being written this cycle
- wreg  in  NWR*AW  write indices
- wdata  in  NWR*XLEN  write data
- wen  in  NWR  write enables
- alloc_en  in  1  mark alloc_reg busy (instruction issued with destination)
- alloc_reg  in  AW  register to mark busy
- ready  out  1  init sweep done; writes and allocs accepted

## Operation
- State machine with two states: INIT and RUN. Reset forces INIT, sweep counter = 1, all busy bits = 0.
- INIT: each cycle, write 0 to regs[counter] and increment the counter. When counter == NREGS-1 and that register is written, go to RUN. Writes and allocs are ignored in INIT.
- RUN: the FSM stays in RUN until reset.
- Write (RUN): for each port j with wen[j] and wreg[j] != 0, regs[wreg[j]] <= wdata[j]. If ports collide on the same index, the highest-numbered port wins.
- Read port i:
  - rs == 0 -> 0.
  - Else, if any enabled write port (RUN only) targets rs, return the highest-numbered such port's wdata (bypass).
  - Else return regs[rs].
  - In INIT, reads return regs contents, which are undefined until swept; consumers must wait for ready.
- Busy scoreboard (RUN):
  - An enabled write to r clears busy[r].
  - alloc_en sets busy[alloc_reg].
  - If both target the same r in one cycle, the set wins (the new producer supersedes).
  - alloc_reg == 0 is ignored; busy[0] is always 0.
- rbusy[i] = busy[rs_i] & ~(any enabled write to rs_i this cycle). The bypass makes that data valid now.
- No arithmetic beyond the counter (AW bits); the counter never wraps, because the FSM exits INIT at NREGS-1.

## Timing
- Reset values: ready = 0, busy = all 0, rbusy = 0 for every port, FSM = INIT, counter = 1.
- Async assert takes effect immediately, including mid-sweep or mid-operation; the sweep restarts from register 1.
- Init latency: regs[k] is zeroed at the k-th rising edge after reset_n deasserts. ready goes high after edge NREGS-1 (31 edges at default).
- Read path is combinational (zero latency); bypass is same-cycle.
- Write visible from array on the cycle after the edge.
- Alloc: rbusy reflects the new busy bit on the cycle after the alloc edge.
- An edge with wen and alloc to the same r leaves busy[r] = 1, and regs[r] takes the new data.

## Test plan
- Reset then idle -> ready = 0 for 31 edges and 1 after edge 31; afterwards every register reads 0; reasserting reset_n = 0 at edge 10 drops ready immediately and the full 31-edge count restarts.
- RUN: wen = 2'b11, wreg = {5, 5}, wdata = {0xBBBB0000, 0xAAAA0000} -> same-cycle rdata for rs = 5 is 0xBBBB0000 (port 1 wins); next cycle array read is 0xBBBB0000.
- Write x0 with 0xDEADBEEF on both ports -> rs = 0 reads 0, both during the cycle and after.
- alloc x7 -> next cycle rbusy = 1 for rs = 7; cycle with wen to x7 data 0x1234 -> rbusy = 0, rdata = 0x1234; next cycle busy[7] = 0.
- Same edge alloc x9 and write x9 = 0x55 -> after the edge busy[9] = 1 and regs[9] = 0x55.
- During INIT, wen to x3 = 0xFF and alloc x3 -> ignored; after ready, x3 reads 0 and rbusy = 0.
